// File: rtl/fwft_fifo_bram_pkg.sv
// Shared elaboration helpers for the FWFT block-RAM FIFO (fwft_fifo_bram).
package fwft_fifo_bram_pkg;

  // Ceiling log2; clog2(1) = 0. Used for pointer and occupancy widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwft_fifo_bram_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Plain array with no reset so it maps onto block RAM.
module bram_sdp_ram
  import fwft_fifo_bram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read returns the old contents when both ports hit the same address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fwft_fifo_bram.sv
// First-word-fall-through FIFO on a block RAM with a bypass output register.
// Define FWFT_FIFO_SIM_CHECK_EN to enable simulation-only misuse reporting.
module fwft_fifo_bram
  import fwft_fifo_bram_pkg::*;
#(
  parameter int DATA_WIDTH                 = 32,
  parameter int MAX_DEPTH                  = 1024,
  parameter     IGNORE_SAME_LOC_RD_WR_WARNING = "NO"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  nearly_full,
  output logic                  recieve_more_than_0,
  output logic                  recieve_more_than_1
);

  localparam int            AW        = clog2(MAX_DEPTH);
  localparam int            CW        = clog2(MAX_DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR  = AW'(MAX_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(MAX_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1  = CW'(MAX_DEPTH - 1);
  localparam bit            SAME_LOC_WARN_EN = (IGNORE_SAME_LOC_RD_WR_WARNING == "NO");

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic                  byp_sel_q, byp_sel_d;
  logic                  wr_accept, rd_accept, same_loc;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_accept = rd_en && (count_q != '0);
    wr_accept = wr_en && ((count_q != DEPTH_CNT) || rd_accept);

    wr_ptr_d = wr_accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The RAM read at this edge returns stale data when the new head is the
    // word being written right now, so that word is captured here instead.
    same_loc   = wr_accept && (rd_ptr_d == wr_ptr_q);
    byp_sel_d  = same_loc;
    byp_data_d = same_loc ? din : byp_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      byp_data_q <= '0;
      byp_sel_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      byp_data_q <= byp_data_d;
      byp_sel_q  <= byp_sel_d;
    end
  end

  // Read address is the next head so its data lands together with the pointer.
  bram_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  assign full                = (count_q == DEPTH_CNT);
  assign nearly_full         = (count_q >= DEPTH_M1);
  assign recieve_more_than_0 = (count_q != '0);
  assign recieve_more_than_1 = (count_q >= CW'(2));
  assign dout = (count_q == '0) ? '0 : (byp_sel_q ? byp_data_q : ram_rd_data);

`ifdef FWFT_FIFO_SIM_CHECK_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (wr_en && full && !rd_en) begin
        $display("%0t: ERROR fwft_fifo_bram %m: write while full", $time);
      end
      if (rd_en && !recieve_more_than_0) begin
        $display("%0t: ERROR fwft_fifo_bram %m: read while empty", $time);
      end
      if (SAME_LOC_WARN_EN && same_loc) begin
        $display("%0t: WARNING fwft_fifo_bram %m: same-location read/write at address %0d",
                 $time, wr_ptr_q);
      end
    end
  end
`else
  // Empty block: keeps the warning switch referenced in the default build.
  if (SAME_LOC_WARN_EN) begin : g_sim_check_off
  end
`endif

endmodule

// File: tb/tb_fwft_fifo_bram.sv
// Scoreboard bench for fwft_fifo_bram: directed cases on a depth-4 FIFO,
// randomized traffic on a depth-5 FIFO, both checked against a reference queue.
module tb_fwft_fifo_bram;

  localparam int DW      = 8;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 5;

  logic          clk    = 1'b0;
  logic          reset  = 1'b1;
  logic [DW-1:0] din    = '0;
  logic          wr_en  = 1'b0;
  logic          rd_en  = 1'b0;
  bit            sel    = 1'b0;
  bit            mon_en = 1'b0;

  logic          wr_a, rd_a, wr_b, rd_b;
  logic [DW-1:0] dout_a, dout_b, dout_m;
  logic          full_a, nf_a, m0_a, m1_a;
  logic          full_b, nf_b, m0_b, m1_b;
  logic          full_m, nf_m, m0_m, m1_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign wr_a = wr_en & ~sel;
  assign rd_a = rd_en & ~sel;
  assign wr_b = wr_en & sel;
  assign rd_b = rd_en & sel;

  assign dout_m = sel ? dout_b : dout_a;
  assign full_m = sel ? full_b : full_a;
  assign nf_m   = sel ? nf_b   : nf_a;
  assign m0_m   = sel ? m0_b   : m0_a;
  assign m1_m   = sel ? m1_b   : m1_a;

  fwft_fifo_bram #(.DATA_WIDTH(DW), .MAX_DEPTH(DEPTH_A)) u_dut_a (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_a), .rd_en(rd_a),
    .dout(dout_a), .full(full_a), .nearly_full(nf_a),
    .recieve_more_than_0(m0_a), .recieve_more_than_1(m1_a)
  );

  fwft_fifo_bram #(.DATA_WIDTH(DW), .MAX_DEPTH(DEPTH_B)) u_dut_b (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_b), .rd_en(rd_b),
    .dout(dout_b), .full(full_b), .nearly_full(nf_b),
    .recieve_more_than_0(m0_b), .recieve_more_than_1(m1_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_state(input string name, input logic [DW-1:0] d,
                              input bit f, input bit nf, input bit m0, input bit m1);
    check({name, "_dout"}, 32'(dout_m), 32'(d));
    check({name, "_full"}, 32'(full_m), 32'(f));
    check({name, "_nearly_full"}, 32'(nf_m), 32'(nf));
    check({name, "_more0"}, 32'(m0_m), 32'(m0));
    check({name, "_more1"}, 32'(m1_m), 32'(m1));
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next.
  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reference model: a plain queue of stored words, advanced once per cycle.
  logic [DW-1:0] model_q[$];
  int            depth = DEPTH_A;
  int            mcnt;
  bit            rd_ok, wr_ok;

  always @(negedge clk) begin
    if (mon_en) begin
      mcnt = model_q.size();
      if (reset) begin
        check("mon_reset_dout", 32'(dout_m), 32'd0);
        check("mon_reset_flags", 32'({full_m, nf_m, m0_m, m1_m}), 32'd0);
        model_q.delete();
      end else begin
        check("mon_full", 32'(full_m), 32'(mcnt == depth));
        check("mon_nearly_full", 32'(nf_m), 32'(mcnt >= depth - 1));
        check("mon_more0", 32'(m0_m), 32'(mcnt >= 1));
        check("mon_more1", 32'(m1_m), 32'(mcnt >= 2));
        if (mcnt > 0) begin
          check("mon_dout", 32'(dout_m), 32'(model_q[0]));
        end
        rd_ok = rd_en && (mcnt > 0);
        wr_ok = wr_en && ((mcnt < depth) || rd_ok);
        if (rd_ok) void'(model_q.pop_front());
        if (wr_ok) model_q.push_back(din);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wp;

    repeat (2) @(posedge clk);
    #3;
    expect_state("reset", 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single write falls through after one edge.
    drive(1, 0, 8'hA5);
    expect_state("wr_a5", 8'hA5, 0, 0, 1, 0);
    drive(0, 1, 8'h00);
    check("pop_a5_empty", 32'(m0_m), 32'd0);

    // Fill to full, drop an extra write, drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, DW'(i));
      check("fill_nearly_full", 32'(nf_m), 32'(i >= 3));
      check("fill_full", 32'(full_m), 32'(i == 4));
    end
    drive(1, 0, 8'h05);
    check("drop_full", 32'(full_m), 32'd1);
    check("drop_head", 32'(dout_m), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_head", 32'(dout_m), 32'(i));
      drive(0, 1, 8'h00);
    end
    check("drain_empty", 32'(m0_m), 32'd0);

    // Read and write together with one word stored.
    drive(1, 0, 8'h07);
    check("one_head", 32'(dout_m), 32'h07);
    drive(1, 1, 8'h09);
    expect_state("rw_one", 8'h09, 0, 0, 1, 0);
    drive(0, 1, 8'h00);

    // Full FIFO with read+write across pointer wrap.
    for (int i = 0; i < 4; i++) drive(1, 0, DW'(8'h10 + i));
    check("wrap_start_full", 32'(full_m), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("wrap_head", 32'(dout_m), (k < 4) ? 32'(8'h10 + k) : 32'(8'h20 + k - 4));
      drive(1, 1, DW'(8'h20 + k));
      check("wrap_full", 32'(full_m), 32'd1);
    end
    for (int k = 2; k < 6; k++) begin
      check("wrap_drain", 32'(dout_m), 32'(8'h20 + k));
      drive(0, 1, 8'h00);
    end
    check("wrap_empty", 32'(m0_m), 32'd0);

    // Asynchronous reset between edges with three words stored.
    drive(1, 0, 8'h31);
    drive(1, 0, 8'h32);
    drive(1, 0, 8'h33);
    check("pre_rst_more1", 32'(m1_m), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_rst", 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 0, 8'h11);
    expect_state("post_rst", 8'h11, 0, 0, 1, 0);
    drive(0, 1, 8'h00);

    // Random traffic on the depth-5 instance, alternating fill and drain bias.
    mon_en = 1'b0;
    sel    = 1'b1;
    depth  = DEPTH_B;
    reset  = 1'b1;
    model_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      wp    = (((i / 500) % 2) == 0) ? 70 : 35;
      wr_en = ($urandom_range(0, 99) < wp);
      rd_en = ($urandom_range(0, 99) < (105 - wp));
      din   = DW'($urandom);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
